uart_cmd_controller: RTL and testbench
======================================

# uart_cmd_controller

Packet controller between the UART receive processor and the VGA drawing logic. Buffers received frames, parses them into fixed-format command packets, and issues drawing commands over a valid/ready handshake. Owns the line-format configuration (parity, parity type, stop bits, frame length) that drives the receive processor, so the host can reconfigure the link in-band.

## Interface
- FIFO_DEPTH, 4, frame buffer entries; power of two, ≥2
- TIMEOUT, 640, idle clk_16bd cycles mid-packet before abort (4 character times at 16x)
- clk_16bd  in  1  16x baud clock
- rst  in  1  asynchronous, active-high reset
- frame  in  9  received frame from receive processor; bits[7:0] used, bit 8 ignored
- frame_valid  in  1  one-cycle strobe, frame valid
- cfg_parity  out  1  parity enable to receive processor
- cfg_parity_type  out  1  0 even, 1 odd
- cfg_stop_bits  out  1  0 one stop bit, 1 two
- cfg_frame_length  out  4  data bits per frame
- cmd_valid  out  1  command available
- cmd_ready  in  1  consumer accepts command
- cmd_op  out  2  00 PIXEL, 10 CLEAR
- cmd_x, cmd_y, cmd_color  out  8 each  PIXEL payload; 0 for CLEAR
- err_valid  out  1  one-cycle error strobe
- err_code  out  3  1 sync, 2 bad op, 3 timeout, 4 overflow, 5 checksum, 6 bad config

## Operation
- Header byte: [7:4] must be 4'hA, [3:2] op, [1:0] ignored. Ops: 00 PIXEL (payload x, y, color), 01 CONFIG (1 payload byte), 10 CLEAR (no payload), 11 illegal.
- CONFIG payload: bit0 parity, bit1 parity_type, bit2 stop_bits, [7:4] frame_length. frame_length outside 5..9 rejects the whole byte, keeps old config, err 6.
- FSM states: IDLE (wait header), PAYLOAD (collect bytes), CHECK (checksum, macro only), ISSUE (cmd_valid high), APPLY (update cfg).
- IDLE: pop header. Bad sync: err 1, stay IDLE. Op 11: err 2, stay IDLE. CLEAR with no payload goes to ISSUE directly.
- PAYLOAD: pop one byte per cycle when FIFO non-empty. After the last byte, go to ISSUE (PIXEL) or APPLY (CONFIG).
- ISSUE: hold cmd_* stable until cmd_valid && cmd_ready, then go to IDLE. No pops in ISSUE or APPLY; the FIFO absorbs frames.
- APPLY: cfg outputs update, then go to IDLE. No command is issued.
- Timeout counter runs in PAYLOAD/CHECK only while the FIFO is empty and clears on every pop. Reaching TIMEOUT: err 3, go to IDLE, partial packet discarded.
- FIFO overflow: a push while full with no pop in the same cycle drops the incoming frame, err 4. Push and pop in the same cycle while full is legal and no data is lost.
- Error priority in the same cycle: overflow > others. A lower-priority error in that cycle is not reported.

## Timing
- Reset values: cmd_valid 0, cmd_op/x/y/color 0, err_valid 0, err_code 0, cfg_parity 0, cfg_parity_type 0, cfg_stop_bits 0, cfg_frame_length 8, FSM IDLE, FIFO empty, timeout 0.
- frame_valid at cycle N: entry visible in FIFO at N+1, earliest pop N+1.
- cmd_valid rises on the cycle after the last payload pop. It is a registered output and never depends combinationally on cmd_ready.
- cfg outputs change on the cycle after the CONFIG payload pop, or the checksum pop when the macro is set.
- err_valid/err_code are registered and asserted for exactly one cycle.
- Reset mid-packet or mid-ISSUE: all state cleared immediately and the pending command is lost.

## Configuration
- UART_CMD_CHECKSUM_EN defined: every packet carries a trailing byte equal to the XOR of the header and payload bytes. CHECK state compares them. Mismatch: err 5, packet discarded (no command, no cfg change).
- Not defined: no trailing byte and no CHECK state. Packets complete on the last payload byte.

## Structure
- Shared package holds:
  - op encodings
  - err_code constants
  - SYNC_NIBBLE = 4'hA
  - default config values
  - payload length per op
- Sub-module frame_fifo (parameterized depth, 8-bit data, push/pop/full/empty, simultaneous push+pop when full) holds the frame buffer. The FSM stays in the top module.

## Test plan
- Bytes A0,10,20,33 -> cmd_valid with op 00, x 0x10, y 0x20, color 0x33. Holding cmd_ready low 5 cycles keeps outputs stable.
- Bytes A4,9F -> cfg_frame_length 9, stop_bits 1, parity_type 1, parity 1. No cmd_valid.
- Byte A4 then 0x30 (length 3) -> err 6, cfg unchanged (8/0/0/0).
- Byte 0x55 -> err 1. Byte AC -> err 2. Byte A8 -> CLEAR command with zero payload.
- Byte A0 then no frames for 640 cycles -> err 3, FSM IDLE, next A8 accepted normally.
- cmd_ready held low while FIFO_DEPTH+1 frames arrive -> err 4 on the last. The first FIFO_DEPTH frames are processed after release. With UART_CMD_CHECKSUM_EN, bytes A8,00 -> err 5 and A8,A8 -> CLEAR.

Source files
------------

// File: rtl/uart_cmd_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_controller_pkg
// Description : Shared definitions for the UART command controller: opcode
//               and error encodings, header sync nibble, power-on line
//               configuration, FSM state type and payload length per opcode.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_controller_pkg;

  // Header opcodes (header bits [3:2])
  localparam logic [1:0] OP_PIXEL   = 2'b00;
  localparam logic [1:0] OP_CONFIG  = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  // err_code values
  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_SYNC       = 3'd1;
  localparam logic [2:0] ERR_BAD_OP     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW   = 3'd4;
  localparam logic [2:0] ERR_CHECKSUM   = 3'd5;
  localparam logic [2:0] ERR_BAD_CONFIG = 3'd6;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;

  // Line configuration after reset and the accepted frame-length window
  localparam logic       DEF_PARITY       = 1'b0;
  localparam logic       DEF_PARITY_TYPE  = 1'b0;
  localparam logic       DEF_STOP_BITS    = 1'b0;
  localparam logic [3:0] DEF_FRAME_LENGTH = 4'd8;
  localparam logic [3:0] MIN_FRAME_LENGTH = 4'd5;
  localparam logic [3:0] MAX_FRAME_LENGTH = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_APPLY   = 3'd4
  } state_t;

  // Number of payload bytes following the header for each opcode
  function automatic logic [1:0] payload_len(input logic [1:0] op);
    case (op)
      OP_PIXEL:  payload_len = 2'd3;
      OP_CONFIG: payload_len = 2'd1;
      default:   payload_len = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_controller_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_controller_frame_fifo
// Description : Byte FIFO buffering received frames. A push while full is
//               only accepted when a pop happens in the same cycle.
// Ports       : clk_16bd, rst (async, active-high)
//               push/push_data  - write strobe and byte
//               pop/pop_data    - read strobe, head byte (valid when !empty)
//               full/empty      - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_controller_frame_fifo
  import uart_cmd_controller_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_16bd,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_16bd) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_controller
// Description : Buffers UART frames, parses header/payload command packets,
//               issues PIXEL/CLEAR drawing commands over valid/ready and
//               applies in-band CONFIG packets to the receive-line settings.
// Ports       : clk_16bd, rst (async, active-high)
//               frame[8:0]/frame_valid        - received frames (bit 8 unused)
//               cfg_parity/_parity_type/_stop_bits/_frame_length - line cfg
//               cmd_valid/cmd_ready/cmd_op/cmd_x/cmd_y/cmd_color - commands
//               err_valid/err_code             - one-cycle error report
// Build macro : UART_CMD_CHECKSUM_EN - packets carry a trailing XOR byte
//               verified in the CHECK state.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_controller
  import uart_cmd_controller_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 640
) (
  input  logic       clk_16bd,
  input  logic       rst,
  input  logic [8:0] frame,
  input  logic       frame_valid,
  output logic       cfg_parity,
  output logic       cfg_parity_type,
  output logic       cfg_stop_bits,
  output logic [3:0] cfg_frame_length,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_op,
  output logic [7:0] cmd_x,
  output logic [7:0] cmd_y,
  output logic [7:0] cmd_color,
  output logic       err_valid,
  output logic [2:0] err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d, idx_q, idx_d;
  logic [7:0]    x_q, x_d, y_q, y_d, c_q, c_d, cksum_q, cksum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [1:0]    cmd_op_q, cmd_op_d;
  logic [7:0]    cmd_x_q, cmd_x_d, cmd_y_q, cmd_y_d, cmd_color_q, cmd_color_d;
  logic          par_q, par_d, ptype_q, ptype_d, stop_q, stop_d;
  logic [3:0]    flen_q, flen_d;
  logic          err_valid_q, err_valid_d;
  logic [2:0]    err_code_q, err_code_d;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_data;
  logic          done;
  logic          unused_frame_msb;

  assign unused_frame_msb = frame[8];

  // Only the parsing states consume bytes; ISSUE/APPLY leave them buffered
  assign fifo_pop = !fifo_empty &&
                    (state_q == ST_IDLE || state_q == ST_PAYLOAD || state_q == ST_CHECK);

  uart_cmd_controller_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_frame_fifo (
    .clk_16bd  (clk_16bd),
    .rst       (rst),
    .push      (frame_valid),
    .push_data (frame[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    c_d         = c_q;
    cksum_d     = cksum_q;
    tmo_d       = '0;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_x_d     = cmd_x_q;
    cmd_y_d     = cmd_y_q;
    cmd_color_d = cmd_color_q;
    par_d       = par_q;
    ptype_d     = ptype_q;
    stop_d      = stop_q;
    flen_d      = flen_q;
    err_valid_d = 1'b0;
    err_code_d  = ERR_NONE;
    done        = 1'b0;  // whole packet received (and verified) this cycle

    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          op_d    = fifo_data[3:2];
          idx_d   = 2'd0;
          cksum_d = fifo_data;
          if (fifo_data[7:4] != SYNC_NIBBLE) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_SYNC;
          end else if (fifo_data[3:2] == OP_ILLEGAL) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_BAD_OP;
          end else if (payload_len(fifo_data[3:2]) != 2'd0) begin
            state_d = ST_PAYLOAD;
          end else begin
`ifdef UART_CMD_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            done = 1'b1;
`endif
          end
        end
      end
      ST_PAYLOAD: begin
        if (fifo_pop) begin
          cksum_d = cksum_q ^ fifo_data;
          idx_d   = idx_q + 2'd1;
          case (idx_q)
            2'd0:    x_d = fifo_data;
            2'd1:    y_d = fifo_data;
            default: c_d = fifo_data;
          endcase
          if (idx_q == payload_len(op_q) - 2'd1) begin
`ifdef UART_CMD_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            done = 1'b1;
`endif
          end
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      ST_CHECK: begin
        if (fifo_pop) begin
          if (fifo_data != cksum_q) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_CHECKSUM;
            state_d     = ST_IDLE;
          end else begin
            done = 1'b1;
          end
        end
      end
`endif
      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Idle gap mid-packet; in these states an empty FIFO is the only reason
    // not to pop, so !fifo_pop means "waiting for a byte".
    if ((state_q == ST_PAYLOAD || state_q == ST_CHECK) && !fifo_pop) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
        state_d     = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    // x_d/y_d/c_d already include the byte popped this cycle
    if (done) begin
      case (op_d)
        OP_PIXEL: begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_PIXEL;
          cmd_x_d     = x_d;
          cmd_y_d     = y_d;
          cmd_color_d = c_d;
        end
        OP_CLEAR: begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_CLEAR;
          cmd_x_d     = 8'd0;
          cmd_y_d     = 8'd0;
          cmd_color_d = 8'd0;
        end
        default: begin
          if (x_d[7:4] >= MIN_FRAME_LENGTH && x_d[7:4] <= MAX_FRAME_LENGTH) begin
            par_d   = x_d[0];
            ptype_d = x_d[1];
            stop_d  = x_d[2];
            flen_d  = x_d[7:4];
            state_d = ST_APPLY;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_BAD_CONFIG;
            state_d     = ST_IDLE;
          end
        end
      endcase
    end

    // Overflow masks any other error raised in the same cycle
    if (frame_valid && fifo_full && !fifo_pop) begin
      err_valid_d = 1'b1;
      err_code_d  = ERR_OVERFLOW;
    end
  end

  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PIXEL;
      idx_q       <= 2'd0;
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      c_q         <= 8'd0;
      cksum_q     <= 8'd0;
      tmo_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 2'd0;
      cmd_x_q     <= 8'd0;
      cmd_y_q     <= 8'd0;
      cmd_color_q <= 8'd0;
      par_q       <= DEF_PARITY;
      ptype_q     <= DEF_PARITY_TYPE;
      stop_q      <= DEF_STOP_BITS;
      flen_q      <= DEF_FRAME_LENGTH;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      c_q         <= c_d;
      cksum_q     <= cksum_d;
      tmo_q       <= tmo_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_x_q     <= cmd_x_d;
      cmd_y_q     <= cmd_y_d;
      cmd_color_q <= cmd_color_d;
      par_q       <= par_d;
      ptype_q     <= ptype_d;
      stop_q      <= stop_d;
      flen_q      <= flen_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_valid        = cmd_valid_q;
  assign cmd_op           = cmd_op_q;
  assign cmd_x            = cmd_x_q;
  assign cmd_y            = cmd_y_q;
  assign cmd_color        = cmd_color_q;
  assign cfg_parity       = par_q;
  assign cfg_parity_type  = ptype_q;
  assign cfg_stop_bits    = stop_q;
  assign cfg_frame_length = flen_q;
  assign err_valid        = err_valid_q;
  assign err_code         = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_cmd_controller
// Description : Scoreboard bench for uart_cmd_controller. Packets are built
//               at byte level; expected commands, errors and config updates
//               are queued when sent and matched by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_controller;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 640;

  logic       clk_16bd = 1'b0;
  logic       rst;
  logic [8:0] frame;
  logic       frame_valid;
  logic       cfg_parity, cfg_parity_type, cfg_stop_bits;
  logic [3:0] cfg_frame_length;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_x, cmd_y, cmd_color;
  logic       err_valid;
  logic [2:0] err_code;

  always #5 clk_16bd = ~clk_16bd;

  uart_cmd_controller #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_16bd(clk_16bd), .rst(rst), .frame(frame), .frame_valid(frame_valid),
    .cfg_parity(cfg_parity), .cfg_parity_type(cfg_parity_type),
    .cfg_stop_bits(cfg_stop_bits), .cfg_frame_length(cfg_frame_length),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
    .err_valid(err_valid), .err_code(err_code)
  );

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] x, y, c;
  } cmd_t;

  cmd_t       exp_cmds[$];
  logic [2:0] exp_errs[$];
  logic [6:0] exp_cfgs[$];          // {frame_length, stop, parity_type, parity}
  logic [6:0] model_cfg = 7'h40;     // length 8, everything else 0
  logic [6:0] prev_cfg;
  int         n_vec = 0, n_bad = 0;
  int         ready_mode = 1;        // 0 random, 1 held low, 2 held high
  logic       mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_vec++;
    n_bad++;
    $display("FAIL %s: unexpected output 0x%0h", name, act);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_16bd) begin
    cmd_t       e;
    logic [2:0] ee;
    logic [6:0] cur;
    cur = {cfg_frame_length, cfg_stop_bits, cfg_parity_type, cfg_parity};
    if (rst || !mon_en) begin
      prev_cfg = cur;
    end else begin
      if (cmd_valid && cmd_ready) begin
        if (exp_cmds.size() == 0) flag("cmd_unexpected", {6'd0, cmd_op, cmd_x, cmd_y, cmd_color});
        else begin
          e = exp_cmds.pop_front();
          chk("cmd", {6'd0, cmd_op, cmd_x, cmd_y, cmd_color}, {6'd0, e.op, e.x, e.y, e.c});
        end
      end
      if (err_valid) begin
        if (exp_errs.size() == 0) flag("err_unexpected", {29'd0, err_code});
        else begin
          ee = exp_errs.pop_front();
          chk("err_code", {29'd0, err_code}, {29'd0, ee});
        end
      end
      if (cur !== prev_cfg) begin
        if (exp_cfgs.size() == 0) flag("cfg_unexpected", {25'd0, cur});
        else chk("cfg", {25'd0, cur}, {25'd0, exp_cfgs.pop_front()});
        prev_cfg = cur;
      end
    end
  end

  // ---------------- consumer ready driver ----------------
  initial begin
    int low;
    low = 0;
    cmd_ready = 1'b0;
    forever begin
      @(posedge clk_16bd); #1;
      case (ready_mode)
        0: begin
          if (low >= 3) cmd_ready = 1'b1;
          else cmd_ready = 1'($urandom_range(0, 1));
          low = cmd_ready ? 0 : low + 1;
        end
        1:       cmd_ready = 1'b0;
        default: cmd_ready = 1'b1;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk_16bd); #1;
    frame       = {1'($urandom_range(0, 1)), b};
    frame_valid = 1'b1;
    @(posedge clk_16bd); #1;
    frame_valid = 1'b0;
    frame       = 9'($urandom);
    repeat (gap) @(posedge clk_16bd);
  endtask

  // Sends n bytes; with the checksum build, appends XOR of them (optionally corrupted)
  task automatic send_pkt(input int n, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3,
                          input int gap, input bit bad_ck);
    logic [7:0] b[4];
    logic [7:0] x;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      x ^= b[i];
      send_byte(b[i], gap);
    end
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(bad_ck ? (x ^ 8'h01) : x, gap);
`else
    if (bad_ck) x = 8'd0;
`endif
  endtask

  task automatic exp_cmd(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] c);
    exp_cmds.push_back({op, x, y, c});
  endtask

  task automatic exp_cfg(input logic [6:0] c);
    exp_cfgs.push_back(c);
    model_cfg = c;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_cmds.size() != 0 || exp_errs.size() != 0 || exp_cfgs.size() != 0) && t < 3000) begin
      @(posedge clk_16bd);
      t++;
    end
    chk("drain_cmd", exp_cmds.size(), 0);
    chk("drain_err", exp_errs.size(), 0);
    chk("drain_cfg", exp_cfgs.size(), 0);
    repeat (5) @(posedge clk_16bd);
  endtask

  task automatic wait_cmd_valid(input string name);
    int t;
    t = 0;
    while (!cmd_valid && t < 50) begin
      @(negedge clk_16bd);
      t++;
    end
    chk(name, {31'd0, cmd_valid}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; frame = '0; frame_valid = 1'b0;
    repeat (3) @(posedge clk_16bd); #1;
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_cmd_fields", {6'd0, cmd_op, cmd_x, cmd_y, cmd_color}, 32'd0);
    chk("rst_err", {28'd0, err_valid, err_code}, 32'd0);
    chk("rst_cfg", {25'd0, cfg_frame_length, cfg_stop_bits, cfg_parity_type, cfg_parity}, 32'h40);
    rst = 1'b0;
    mon_en = 1'b1;

    // PIXEL held off by cmd_ready low; outputs must stay put
    ready_mode = 1;
    exp_cmd(2'b00, 8'h10, 8'h20, 8'h33);
    send_pkt(4, 8'hA0, 8'h10, 8'h20, 8'h33, 0, 1'b0);
    wait_cmd_valid("pix_valid_seen");
    repeat (5) begin
      @(negedge clk_16bd);
      chk("hold_valid", {31'd0, cmd_valid}, 32'd1);
      chk("hold_fields", {6'd0, cmd_op, cmd_x, cmd_y, cmd_color}, 32'h00102033);
    end
    ready_mode = 2;
    wait_drain();
    ready_mode = 0;

    // CONFIG with illegal length 3
    exp_errs.push_back(3'd6);
    send_pkt(2, 8'hA4, 8'h30, 8'h00, 8'h00, 2, 1'b0);
    wait_drain();
    chk("cfg_kept", {25'd0, cfg_frame_length, cfg_stop_bits, cfg_parity_type, cfg_parity}, 32'h40);

    // bad sync, illegal op, CLEAR
    exp_errs.push_back(3'd1);
    send_byte(8'h55, 2);
    exp_errs.push_back(3'd2);
    send_byte(8'hAC, 2);
    exp_cmd(2'b10, 8'h00, 8'h00, 8'h00);
    send_pkt(1, 8'hA8, 8'h00, 8'h00, 8'h00, 2, 1'b0);
    wait_drain();

    // reset while a command is pending: command is lost, reset is asynchronous
    ready_mode = 1;
    send_pkt(1, 8'hA8, 8'h00, 8'h00, 8'h00, 2, 1'b0);
    wait_cmd_valid("issue_before_rst");
    @(posedge clk_16bd); #1;
    rst = 1'b1;
    #1;
    chk("async_rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    repeat (2) @(posedge clk_16bd); #1;
    rst = 1'b0;
    ready_mode = 0;
    exp_cmd(2'b10, 8'h00, 8'h00, 8'h00);
    send_pkt(1, 8'hA8, 8'h00, 8'h00, 8'h00, 2, 1'b0);
    wait_drain();

    // valid CONFIG
    exp_cfg(7'h4F);
    send_pkt(2, 8'hA4, 8'h9F, 8'h00, 8'h00, 2, 1'b0);
    wait_drain();

    // mid-packet timeout
    exp_errs.push_back(3'd3);
    send_byte(8'hA0, 0);
    repeat (600) @(posedge clk_16bd);
    chk("tmo_not_early", exp_errs.size(), 1);
    repeat (100) @(posedge clk_16bd);
    chk("tmo_fired", exp_errs.size(), 0);
    exp_cmd(2'b10, 8'h00, 8'h00, 8'h00);
    send_pkt(1, 8'hA8, 8'h00, 8'h00, 8'h00, 2, 1'b0);
    wait_drain();

    // overflow while a command is stalled
    ready_mode = 1;
    exp_cmd(2'b10, 8'h00, 8'h00, 8'h00);
    send_pkt(1, 8'hA8, 8'h00, 8'h00, 8'h00, 4, 1'b0);
`ifdef UART_CMD_CHECKSUM_EN
    for (int i = 0; i < FIFO_DEPTH / 2; i++) exp_cmd(2'b10, 8'h00, 8'h00, 8'h00);
`else
    for (int i = 0; i < FIFO_DEPTH; i++) exp_cmd(2'b10, 8'h00, 8'h00, 8'h00);
`endif
    for (int i = 0; i < FIFO_DEPTH; i++) send_byte(8'hA8, 0);
    exp_errs.push_back(3'd4);
    send_byte(8'h55, 0);
    @(negedge clk_16bd);
    chk("ovf_stalled", {31'd0, cmd_valid}, 32'd1);
    ready_mode = 0;
    wait_drain();

`ifdef UART_CMD_CHECKSUM_EN
    exp_errs.push_back(3'd5);
    send_byte(8'hA8, 1);
    send_byte(8'h00, 3);
    exp_cmd(2'b10, 8'h00, 8'h00, 8'h00);
    send_byte(8'hA8, 1);
    send_byte(8'hA8, 3);
    wait_drain();
`endif

    // randomized packet mix
    for (int i = 0; i < 60; i++) begin
      int         kind, gap;
      logic [7:0] h, x, y, c;
      logic [3:0] fl;
      logic [6:0] nc;
      kind = $urandom_range(0, 6);
      gap  = $urandom_range(3, 8);
      x = 8'($urandom); y = 8'($urandom); c = 8'($urandom);
      case (kind)
        0, 1: begin
          h = {4'hA, 2'b00, 2'($urandom)};
          exp_cmd(2'b00, x, y, c);
          send_pkt(4, h, x, y, c, gap, 1'b0);
        end
        2: begin
          h = {4'hA, 2'b10, 2'($urandom)};
          exp_cmd(2'b10, 8'h00, 8'h00, 8'h00);
          send_pkt(1, h, 8'h00, 8'h00, 8'h00, gap, 1'b0);
        end
        3: begin
          do begin
            fl = 4'($urandom_range(5, 9));
            nc = {fl, 3'($urandom)};
          end while (nc == model_cfg);
          h = {4'hA, 2'b01, 2'($urandom)};
          exp_cfg(nc);
          send_pkt(2, h, {fl, 1'($urandom), nc[2:0]}, 8'h00, 8'h00, gap, 1'b0);
        end
        4: begin
          fl = 4'($urandom_range(0, 10));
          if (fl >= 4'd5) fl = fl + 4'd5;
          h = {4'hA, 2'b01, 2'($urandom)};
          exp_errs.push_back(3'd6);
          send_pkt(2, h, {fl, 4'($urandom)}, 8'h00, 8'h00, gap, 1'b0);
        end
        5: begin
          do h = 8'($urandom); while (h[7:4] == 4'hA);
          exp_errs.push_back(3'd1);
          send_byte(h, gap);
        end
        default: begin
`ifdef UART_CMD_CHECKSUM_EN
          if ($urandom_range(0, 1) == 1) begin
            h = {4'hA, 2'b00, 2'($urandom)};
            exp_errs.push_back(3'd5);
            send_pkt(4, h, x, y, c, gap, 1'b1);
          end else
`endif
          begin
            h = {4'hA, 2'b11, 2'($urandom)};
            exp_errs.push_back(3'd2);
            send_byte(h, gap);
          end
        end
      endcase
      repeat ($urandom_range(0, 6)) @(posedge clk_16bd);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
